// File: rtl/hdmi_timing_pkg.sv
// Shared types and the built-in CEA-861 mode table for the HDMI raster generator.
// Table constants are stored at counter width, so every compare is 11/10-bit unsigned.
package hdmi_timing_pkg;

  typedef struct packed {
    logic [10:0] frame_w;
    logic [9:0]  frame_h;
    logic [10:0] act_w;
    logic [9:0]  act_h;
    logic [10:0] hfp;
    logic [10:0] hs;
    logic [9:0]  vfp;
    logic [9:0]  vs;
    logic        sync_pos;
  } hdmi_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } req_state_t;

  localparam logic [1:0] MODE_VIC1  = 2'd0;
  localparam logic [1:0] MODE_VIC2  = 2'd1;
  localparam logic [1:0] MODE_VIC4  = 2'd2;
  localparam logic [1:0] MODE_VIC17 = 2'd3;

  // Positional order: frame_w, frame_h, act_w, act_h, hfp, hs, vfp, vs, sync_pos.
  localparam hdmi_mode_t MODE_TABLE [4] = '{
    '{11'd800,  10'd525, 11'd640,  10'd480, 11'd16,  11'd96, 10'd10, 10'd2, 1'b0},
    '{11'd858,  10'd525, 11'd720,  10'd480, 11'd16,  11'd62, 10'd9,  10'd6, 1'b0},
    '{11'd1650, 10'd750, 11'd1280, 10'd720, 11'd110, 11'd40, 10'd5,  10'd5, 1'b1},
    '{11'd864,  10'd625, 11'd720,  10'd576, 11'd12,  11'd64, 10'd5,  10'd5, 1'b0}
  };

endpackage

// File: rtl/hdmi_sync_decode.sv
// Window decode of de/hsync/vsync and line/frame strobes from the next counter values.
// Purely combinational; the top registers the results alongside cx/cy.
module hdmi_sync_decode
  import hdmi_timing_pkg::*;
(
  input  hdmi_mode_t  mode_entry,
  input  logic [10:0] cx_nxt,
  input  logic [9:0]  cy_nxt,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  logic [10:0] hs_beg;
  logic [10:0] hs_end;
  logic [9:0]  vs_beg;
  logic [9:0]  vs_end;
  logic        h_act;
  logic        v_act;

  assign hs_beg = mode_entry.act_w + mode_entry.hfp;
  assign hs_end = hs_beg + mode_entry.hs;
  assign vs_beg = mode_entry.act_h + mode_entry.vfp;
  assign vs_end = vs_beg + mode_entry.vs;

  assign h_act = (cx_nxt >= hs_beg) && (cx_nxt < hs_end);
  assign v_act = (cy_nxt >= vs_beg) && (cy_nxt < vs_end);

  // XNOR with the polarity bit: positive passes through, negative inverts.
  assign hsync       = h_act ~^ mode_entry.sync_pos;
  assign vsync       = v_act ~^ mode_entry.sync_pos;
  assign de          = (cx_nxt < mode_entry.act_w) && (cy_nxt < mode_entry.act_h);
  assign line_start  = (cx_nxt == 11'd0);
  assign frame_start = (cx_nxt == 11'd0) && (cy_nxt == 10'd0);

endmodule

// File: rtl/hdmi_timing_gen.sv
// Multi-mode CEA-861 raster generator; mode requests are held pending and applied at the frame wrap.
// state   | meaning
// IDLE    | no request outstanding, mode_busy=0
// PEND    | request latched in pend_mode, applied at next frame wrap
module hdmi_timing_gen
  import hdmi_timing_pkg::*;
#(
  parameter logic [1:0]  DEFAULT_MODE = 2'd0,
  parameter logic [10:0] START_X      = 11'd0,
  parameter logic [9:0]  START_Y      = 10'd0
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [1:0]  mode_sel,
  input  logic        mode_req,
  output logic        mode_busy,
  output logic [1:0]  active_mode,
  output logic [10:0] cx,
  output logic [9:0]  cy,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam logic SYNC_IDLE = ~MODE_TABLE[DEFAULT_MODE].sync_pos;

  req_state_t  state, state_nxt;
  logic [1:0]  pend_mode, pend_nxt;
  logic [1:0]  mode_nxt;
  logic [10:0] cx_nxt;
  logic [9:0]  cy_nxt;
  logic        h_end, v_end, frame_wrap;
  hdmi_mode_t  mode_cur;
  logic        de_d, hsync_d, vsync_d, line_start_d, frame_start_d;

  assign mode_cur   = MODE_TABLE[active_mode];
  assign h_end      = (cx == mode_cur.frame_w - 11'd1);
  assign v_end      = (cy == mode_cur.frame_h - 10'd1);
  assign frame_wrap = h_end && v_end;
  assign mode_busy  = (state == ST_PEND);

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_mode;
    mode_nxt  = active_mode;
    cx_nxt    = cx + 11'd1;
    cy_nxt    = cy;
    if (h_end) begin
      cx_nxt = 11'd0;
      cy_nxt = v_end ? 10'd0 : cy + 10'd1;
    end
    case (state)
      ST_IDLE: begin
        if (mode_req) begin
          state_nxt = ST_PEND;
          pend_nxt  = mode_sel;
        end
      end
      ST_PEND: begin
        if (mode_req) pend_nxt = mode_sel;
        // A request arriving on the wrap cycle re-arms PEND for the following frame.
        if (frame_wrap) begin
          mode_nxt  = pend_mode;
          state_nxt = mode_req ? ST_PEND : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  hdmi_sync_decode u_decode (
    .mode_entry  (MODE_TABLE[mode_nxt]),
    .cx_nxt      (cx_nxt),
    .cy_nxt      (cy_nxt),
    .de          (de_d),
    .hsync       (hsync_d),
    .vsync       (vsync_d),
    .line_start  (line_start_d),
    .frame_start (frame_start_d)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state       <= ST_IDLE;
      pend_mode   <= DEFAULT_MODE;
      active_mode <= DEFAULT_MODE;
      cx          <= START_X;
      cy          <= START_Y;
      de          <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_mode   <= pend_nxt;
      active_mode <= mode_nxt;
      cx          <= cx_nxt;
      cy          <= cy_nxt;
      de          <= de_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: a per-cycle reference model feeds an expectation queue,
// plus directed checks on frame period, sync windows and mode-switch behaviour.
module tb_hdmi_timing_gen;

  localparam int DEF_MODE = 0;
  localparam int SX = 100;
  localparam int SY = 500;

  // Reference mode table: frame w/h, active w/h, hfp/hs, vfp/vs, positive polarity.
  int t_fw  [4] = '{800, 858, 1650, 864};
  int t_fh  [4] = '{525, 525, 750, 625};
  int t_w   [4] = '{640, 720, 1280, 720};
  int t_h   [4] = '{480, 480, 720, 576};
  int t_hfp [4] = '{16, 16, 110, 12};
  int t_hs  [4] = '{96, 62, 40, 64};
  int t_vfp [4] = '{10, 9, 5, 5};
  int t_vs  [4] = '{2, 6, 5, 5};
  int t_pos [4] = '{0, 0, 1, 0};

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode_sel = 2'd0;
  logic        mode_req = 1'b0;
  logic        mode_busy;
  logic [1:0]  active_mode;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        de, hsync, vsync, line_start, frame_start;

  hdmi_timing_gen #(
    .DEFAULT_MODE(2'd0),
    .START_X(11'd100),
    .START_Y(10'd500)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .mode_sel   (mode_sel),
    .mode_req   (mode_req),
    .mode_busy  (mode_busy),
    .active_mode(active_mode),
    .cx         (cx),
    .cy         (cy),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [1:0]  mode;
    logic        busy;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  int m_cx, m_cy, m_mode, m_pend;
  bit m_busy;

  // One clock: drive inputs, advance the model, queue its expectation, compare after the edge.
  task automatic tick(input bit rst, input bit req, input int sel);
    exp_t e, got;
    bit wrap, ha, va;
    reset    = rst;
    mode_req = req;
    mode_sel = sel[1:0];
    if (rst) begin
      m_cx = SX; m_cy = SY; m_mode = DEF_MODE; m_busy = 0;
    end else begin
      wrap = (m_cx == t_fw[m_mode] - 1) && (m_cy == t_fh[m_mode] - 1);
      if (m_cx == t_fw[m_mode] - 1) begin
        m_cx = 0;
        m_cy = (m_cy == t_fh[m_mode] - 1) ? 0 : m_cy + 1;
      end else begin
        m_cx = m_cx + 1;
      end
      if (wrap && m_busy) begin
        m_mode = m_pend;
        m_busy = 0;
      end
      if (req) begin
        m_pend = sel;
        m_busy = 1;
      end
    end
    e.cx   = m_cx[10:0];
    e.cy   = m_cy[9:0];
    e.mode = m_mode[1:0];
    e.busy = m_busy;
    if (rst) begin
      e.de = 0; e.ls = 0; e.fs = 0;
      e.hs = (t_pos[DEF_MODE] == 0);
      e.vs = (t_pos[DEF_MODE] == 0);
    end else begin
      ha = (m_cx >= t_w[m_mode] + t_hfp[m_mode]) && (m_cx < t_w[m_mode] + t_hfp[m_mode] + t_hs[m_mode]);
      va = (m_cy >= t_h[m_mode] + t_vfp[m_mode]) && (m_cy < t_h[m_mode] + t_vfp[m_mode] + t_vs[m_mode]);
      e.de = (m_cx < t_w[m_mode]) && (m_cy < t_h[m_mode]);
      e.hs = (t_pos[m_mode] != 0) ? ha : !ha;
      e.vs = (t_pos[m_mode] != 0) ? va : !va;
      e.ls = (m_cx == 0);
      e.fs = (m_cx == 0) && (m_cy == 0);
    end
    exp_q.push_back(e);
    @(posedge clk_pixel);
    #1;
    cyc++;
    e = exp_q.pop_front();
    got = {cx, cy, active_mode, mode_busy, de, hsync, vsync, line_start, frame_start};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL model_cycle %0d: got cx=%0d cy=%0d mode=%0d busy=%b de=%b hs=%b vs=%b ls=%b fs=%b, want cx=%0d cy=%0d mode=%0d busy=%b de=%b hs=%b vs=%b ls=%b fs=%b",
               cyc, got.cx, got.cy, got.mode, got.busy, got.de, got.hs, got.vs, got.ls, got.fs,
               e.cx, e.cy, e.mode, e.busy, e.de, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  // Advance until the model sits on the last pixel of the current frame; returns ticks used.
  task automatic run_to_last(input int limit, output int used);
    used = 0;
    while (!(m_cx == t_fw[m_mode] - 1 && m_cy == t_fh[m_mode] - 1) && used < limit) begin
      tick(0, 0, 0);
      used++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) tick(1, 1, 3);
    total++;
    if (cx !== 11'd100 || cy !== 10'd500) begin
      bad++; $display("FAIL reset_counters: got cx=%0d cy=%0d, want 100/500", cx, cy);
    end
    total++;
    if (active_mode !== 2'd0 || mode_busy !== 1'b0) begin
      bad++; $display("FAIL reset_mode: got mode=%0d busy=%b, want 0/0", active_mode, mode_busy);
    end
    total++;
    if ({de, line_start, frame_start, hsync, vsync} !== 5'b00011) begin
      bad++; $display("FAIL reset_flags: got de/ls/fs/hs/vs=%b, want 00011", {de, line_start, frame_start, hsync, vsync});
    end
  endtask

  // Start offset, frame period, request on the wrap cycle, and VIC1 line windows.
  task automatic test_default_frame();
    int n, used, fs_cnt, de_cnt, hs_lo, hs_first, len;
    tick(0, 0, 0);
    n = 1;
    total++;
    if (cx !== 11'd101 || cy !== 10'd500) begin
      bad++; $display("FAIL start_pos: got cx=%0d cy=%0d, want 101/500", cx, cy);
    end
    fs_cnt = 0;
    used = 0;
    while (!(m_cx == 799 && m_cy == 524) && used < 25000) begin
      tick(0, 0, 0);
      n++; used++;
      if (frame_start) fs_cnt++;
    end
    total++;
    if (used >= 25000) begin
      bad++; $display("FAIL wrap_timeout: got %0d ticks, want < 25000", used);
    end
    tick(0, 1, 2);
    n++;
    total++;
    if (frame_start !== 1'b1 || fs_cnt != 0 || n - 1 != 19899) begin
      bad++; $display("FAIL first_frame_start: got fs=%b early=%0d delay=%0d, want 1/0/19899", frame_start, fs_cnt, n - 1);
    end
    total++;
    if (active_mode !== 2'd0 || mode_busy !== 1'b1) begin
      bad++; $display("FAIL wrap_cycle_req: got mode=%0d busy=%b, want 0/1", active_mode, mode_busy);
    end
    de_cnt = 0; hs_lo = 0; hs_first = -1; len = 0;
    do begin
      if (de) de_cnt++;
      if (!hsync) begin
        hs_lo++;
        if (hs_first < 0) hs_first = cx;
      end
      tick(0, 0, 0);
      len++;
    end while (!line_start && len < 2000);
    total++;
    if (len != 800 || de_cnt != 640) begin
      bad++; $display("FAIL vic1_line: got len=%0d de=%0d, want 800/640", len, de_cnt);
    end
    total++;
    if (hs_lo != 96 || hs_first != 656) begin
      bad++; $display("FAIL vic1_hsync: got low=%0d first=%0d, want 96/656", hs_lo, hs_first);
    end
    total++;
    if (active_mode !== 2'd0 || mode_busy !== 1'b1) begin
      bad++; $display("FAIL still_pending: got mode=%0d busy=%b, want 0/1", active_mode, mode_busy);
    end
  endtask

  task automatic test_mode_switch();
    int used, busy_lo, len, hs_hi, hs_first;
    tick(1, 0, 0);
    tick(0, 0, 0);
    while (m_cy < 510) tick(0, 0, 0);
    tick(0, 1, 2);
    busy_lo = 0; used = 0;
    while (!(m_cx == 799 && m_cy == 524) && used < 25000) begin
      tick(0, 0, 0);
      used++;
      if (mode_busy !== 1'b1 || active_mode !== 2'd0) busy_lo++;
    end
    total++;
    if (busy_lo != 0 || used >= 25000) begin
      bad++; $display("FAIL busy_hold: got drops=%0d ticks=%0d, want 0/<25000", busy_lo, used);
    end
    tick(0, 0, 0);
    total++;
    if (active_mode !== 2'd2 || mode_busy !== 1'b0 || frame_start !== 1'b1) begin
      bad++; $display("FAIL switch_apply: got mode=%0d busy=%b fs=%b, want 2/0/1", active_mode, mode_busy, frame_start);
    end
    len = 0; hs_hi = 0; hs_first = -1;
    do begin
      if (hsync) begin
        hs_hi++;
        if (hs_first < 0) hs_first = cx;
      end
      tick(0, 0, 0);
      len++;
    end while (!line_start && len < 4000);
    total++;
    if (len != 1650 || hs_hi != 40 || hs_first != 1390) begin
      bad++; $display("FAIL vic4_line: got len=%0d hs=%0d first=%0d, want 1650/40/1390", len, hs_hi, hs_first);
    end
  endtask

  // Reset drops a pending request; then two requests in one frame, last one wins.
  task automatic test_reset_pending_double();
    int used, saw_vic2, len, hs_lo;
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 2);
    for (int i = 0; i < 5; i++) tick(0, 0, 0);
    total++;
    if (mode_busy !== 1'b1) begin
      bad++; $display("FAIL pend_set: got busy=%b, want 1", mode_busy);
    end
    tick(1, 0, 0);
    total++;
    if (mode_busy !== 1'b0 || active_mode !== 2'd0 || cx !== 11'd100 || cy !== 10'd500) begin
      bad++; $display("FAIL reset_pending: got busy=%b mode=%0d cx=%0d cy=%0d, want 0/0/100/500", mode_busy, active_mode, cx, cy);
    end
    tick(0, 0, 0);
    tick(0, 1, 1);
    for (int i = 0; i < 300; i++) tick(0, 0, 0);
    tick(0, 1, 3);
    saw_vic2 = 0;
    run_to_last(25000, used);
    tick(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (active_mode == 2'd1) saw_vic2++;
      tick(0, 0, 0);
    end
    total++;
    if (active_mode !== 2'd3 || mode_busy !== 1'b0 || saw_vic2 != 0 || used >= 25000) begin
      bad++; $display("FAIL double_req: got mode=%0d busy=%b vic2=%0d ticks=%0d, want 3/0/0/<25000", active_mode, mode_busy, saw_vic2, used);
    end
    len = 0; hs_lo = 0;
    while (!line_start && len < 2000) begin
      tick(0, 0, 0);
      len++;
    end
    len = 0;
    do begin
      if (!hsync) hs_lo++;
      tick(0, 0, 0);
      len++;
    end while (!line_start && len < 2000);
    total++;
    if (len != 864 || hs_lo != 64) begin
      bad++; $display("FAIL vic17_line: got len=%0d hs_low=%0d, want 864/64", len, hs_lo);
    end
  endtask

  initial begin
    m_cx = SX; m_cy = SY; m_mode = DEF_MODE; m_pend = DEF_MODE; m_busy = 0;
    test_reset();
    test_default_frame();
    test_mode_switch();
    test_reset_pending_double();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
